spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter FRAME_W, default 10, giving the MOSI frame width (command bits [9:8] plus payload [7:0]).
REQ-002 SHALL have parameter DATA_W, default 8, giving the width of the read-data word shifted out on MISO.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, which is also the SPI bit clock, with all sampling on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit; asynchronous active-low reset.
REQ-005 SHALL have port SS_n, input, 1 bit; active-low slave select.
REQ-006 SHALL have port MOSI, input, 1 bit; serial data in, MSB first.
REQ-007 SHALL have port MISO, output, 1 bit; serial read data out, MSB first.
REQ-008 SHALL have port rx_data, output, FRAME_W bits; the assembled frame sent downstream to the memory.
REQ-009 SHALL have port rx_valid, output, 1 bit; a one-cycle strobe marking rx_data as valid.
REQ-010 SHALL have port tx_data, input, DATA_W bits; read data returned by the memory.
REQ-011 SHALL have port tx_valid, input, 1 bit; a one-cycle strobe marking tx_data as valid.
REQ-012 SHALL have port frame_err, output, 1 bit; an abort indication (see Configuration).

Function
REQ-013 SHALL implement the FSM states IDLE, CHK_CMD, WRITE, READ_ADD and READ_DATA.
REQ-014 SHALL move IDLE->CHK_CMD when SS_n=0, and otherwise remain in IDLE.
REQ-015 SHALL, in CHK_CMD, treat the sampled MOSI as the selector bit and not store it: MOSI=0->WRITE; MOSI=1 with rd_addr_seen=0->READ_ADD; MOSI=1 with rd_addr_seen=1->READ_DATA.
REQ-016 SHALL, in WRITE/READ_ADD/READ_DATA, shift MOSI into the rx shift register MSB first, counting bits with a 4-bit counter from 0 to FRAME_W-1.
REQ-017 SHALL, on the cycle after the FRAME_W-th bit is sampled, drive rx_data from the shift register and pulse rx_valid high for exactly 1 cycle.
REQ-018 SHALL ignore further MOSI bits after the frame completes until SS_n=1.
REQ-019 SHALL set rd_addr_seen when a READ_ADD frame's rx_valid fires, and clear it when a READ_DATA frame's rx_valid fires.
REQ-020 SHALL, in READ_DATA after rx_valid, wait with no timeout for tx_valid=1, latch tx_data on that cycle, and drive tx_data[7..0] on MISO over the next 8 cycles, one bit per cycle.
REQ-021 SHALL drive MISO=0 whenever no bit is being shifted out.
REQ-022 SHALL ignore tx_valid outside the READ_DATA wait window.
REQ-023 SHALL return to IDLE from any state on the next edge whenever SS_n=1, discarding any partial frame with no rx_valid; rd_addr_seen is unchanged on abort.
REQ-024 SHALL, if SS_n rises on the same cycle the last bit is sampled, still sample that bit and still issue rx_valid on the following cycle.
REQ-025 SHALL, if SS_n rises during MISO shift-out, stop the shift and drive MISO=0.

Reset
REQ-026 SHALL, while rst_n=0, immediately force state=IDLE, MISO=0, rx_data=0, rx_valid=0, frame_err=0, rd_addr_seen=0 and all counters to 0, independent of clk.
REQ-027 SHALL, on reset mid-frame, drop the partial frame with no rx_valid emitted.

Configuration
REQ-028 SHALL compile frame-abort detection in when macro SPI_FRAME_ERR_EN is defined: frame_err pulses high for 1 cycle when SS_n rises with between 1 and FRAME_W-1 frame bits received.
REQ-029 SHALL, without SPI_FRAME_ERR_EN, tie frame_err to constant 0 and omit the detection logic.

Structure
REQ-030 SHALL take from a shared package spi_pkg: the state enum type, FRAME_W/DATA_W defaults, and the command codes (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data).
REQ-031 SHALL place the MISO serializer (latch plus 8-bit shift-out plus counter) in the sub-module spi_tx_ser.

Verification
REQ-032 SHALL be verified with: selector 0 then frame 00_0000_0101 -> rx_data=10'h005 with a 1-cycle rx_valid.
REQ-033 SHALL be verified with: READ_ADD frame 10_0000_0101, then new SS_n frame selector 1 plus 11_xxxx_xxxx, then tx_valid with tx_data=8'hA5 -> MISO=1,0,1,0,0,1,0,1.
REQ-034 SHALL be verified with: two consecutive selector-1 frames -> the first enters READ_ADD and the second enters READ_DATA, with rd_addr_seen clearing after the second.
REQ-035 SHALL be verified with: SS_n rising after 4 bits -> no rx_valid, state IDLE; frame_err=1 for one cycle only when SPI_FRAME_ERR_EN is defined.
REQ-036 SHALL be verified with: rst_n asserted mid-shift-out -> MISO=0 and state IDLE in the same cycle with no clk edge required.
REQ-037 SHALL be verified with: SS_n rising on the cycle of the 10th bit -> rx_valid still fires once.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: FSM state type, default widths and command codes.
package spi_pkg;

  localparam int FRAME_W_DEF = 10;
  localparam int DATA_W_DEF  = 8;

  // Command codes carried in frame bits [9:8]
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } spi_state_e;

  // True for the states that shift a MOSI frame in
  function automatic logic is_data_state(spi_state_e s);
    return (s == WRITE) || (s == READ_ADD) || (s == READ_DATA);
  endfunction

endpackage

// File: rtl/spi_tx_ser.sv
// MISO serializer: latches a read word and shifts it out MSB first, one bit per clock.
// MISO is low whenever no bit is being shifted, and an abort stops the shift on the next edge.
module spi_tx_ser #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              abort,
  input  logic [DATA_W-1:0] load_data,
  output logic              miso
);

  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [3:0]        cnt_q, cnt_d;

  // Next-state logic: abort wins, then a fresh load, then one shift per clock while bits remain
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (abort) begin
      cnt_d = 4'd0;
    end else if (load) begin
      shreg_d = load_data;
      cnt_d   = 4'(DATA_W);
    end else if (cnt_q != 4'd0) begin
      shreg_d = shreg_q << 1;
      cnt_d   = cnt_q - 4'd1;
    end
  end

  // Serializer registers, cleared immediately by reset so MISO drops without a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= 4'd0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign miso = (cnt_q != 4'd0) && shreg_q[DATA_W-1];

endmodule

// File: rtl/spi_slave.sv
// SPI slave front end for a small memory: decodes the selector bit, assembles
// FRAME_W-bit MOSI frames into rx_data/rx_valid and returns read data on MISO.
// Optional frame-abort detection on frame_err is compiled in with SPI_FRAME_ERR_EN.
module spi_slave
  import spi_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SS_n,
  input  logic               MOSI,
  output logic               MISO,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid,
  output logic               frame_err
);

  localparam logic [3:0] LAST_BIT = 4'(FRAME_W - 1);

  spi_state_e         state_q, state_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-2:0] shift_q, shift_d;
  logic               frame_done_q, frame_done_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               rd_addr_seen_q, rd_addr_seen_d;
  logic               tx_taken_q, tx_taken_d;
  logic               tx_load;

  // FSM next-state, frame assembly and read-data handshake
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    frame_done_d   = frame_done_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_seen_d = rd_addr_seen_q;
    tx_taken_d     = tx_taken_q;
    tx_load        = 1'b0;
    case (state_q)
      IDLE: begin
        bit_cnt_d    = 4'd0;
        frame_done_d = 1'b0;
        tx_taken_d   = 1'b0;
        if (!SS_n) state_d = CHK_CMD;
      end
      CHK_CMD: begin
        bit_cnt_d    = 4'd0;
        frame_done_d = 1'b0;
        if (SS_n)                state_d = IDLE;
        else if (!MOSI)          state_d = WRITE;
        else if (rd_addr_seen_q) state_d = READ_DATA;
        else                     state_d = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (!frame_done_q) begin
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d    = {shift_q, MOSI};
            rx_valid_d   = 1'b1;
            frame_done_d = 1'b1;
            bit_cnt_d    = 4'd0;
            if (state_q == READ_ADD)  rd_addr_seen_d = 1'b1;
            if (state_q == READ_DATA) rd_addr_seen_d = 1'b0;
          end else if (!SS_n) begin
            shift_d   = {shift_q[FRAME_W-3:0], MOSI};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if ((state_q == READ_DATA) && !tx_taken_q && tx_valid && !SS_n) begin
          tx_load    = 1'b1;
          tx_taken_d = 1'b1;
        end
        if (SS_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and frame registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      bit_cnt_q      <= 4'd0;
      shift_q        <= '0;
      frame_done_q   <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      tx_taken_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      frame_done_q   <= frame_done_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      tx_taken_q     <= tx_taken_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

  spi_tx_ser #(
    .DATA_W (DATA_W)
  ) u_tx_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (tx_load),
    .abort     (SS_n),
    .load_data (tx_data),
    .miso      (MISO)
  );

`ifdef SPI_FRAME_ERR_EN
  logic frame_err_q, frame_err_d;

  // A deselect that cuts a frame after at least one bit, short of the completing bit, is an abort
  assign frame_err_d = is_data_state(state_q) && !frame_done_q && SS_n &&
                       (bit_cnt_q != 4'd0) && (bit_cnt_q != LAST_BIT);

  // One-cycle abort pulse register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err_q <= 1'b0;
    else        frame_err_q <= frame_err_d;
  end

  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed frames with rx_data and MISO scoreboards.
module tb_spi_slave;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       SS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       frame_err;

  int errors = 0;
  int checks = 0;
  int rx_seen = 0;
  int rx_pushed = 0;
  logic [9:0] rx_exp_q[$];
  logic       miso_exp_q[$];
  logic       err_exp;

  spi_slave #(
    .FRAME_W (10),
    .DATA_W  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .frame_err (frame_err)
  );

  // 10 ns bit clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then score rx_valid frames and every MISO bit
  task automatic tick();
    @(posedge clk);
    #1;
    if (rx_valid === 1'b1) begin
      rx_seen++;
      if (rx_exp_q.size() == 0) checkOutput("rx_unexpected", 32'(rx_valid), 0);
      else                      checkOutput("rx_data", 32'(rx_data), 32'(rx_exp_q.pop_front()));
    end
    if (miso_exp_q.size() > 0) checkOutput("miso_bit", 32'(MISO), 32'(miso_exp_q.pop_front()));
    else                       checkOutput("miso_idle", 32'(MISO), 0);
  endtask

  task automatic pushTx(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) miso_exp_q.push_back(d[i]);
  endtask

  // Select the slave, send the selector bit, then nbits of the frame MSB first
  task automatic applyStimulus(input logic sel, input logic [9:0] frame, input int nbits,
                               input bit ss_at_last, input spi_state_e exp_state);
    SS_n = 1'b0;
    MOSI = 1'b0;
    tick();
    MOSI = sel;
    tick();
    checkOutput("state_after_sel", 32'(dut.state_q), 32'(exp_state));
    if (nbits == 10) begin
      rx_exp_q.push_back(frame);
      rx_pushed++;
    end
    for (int i = 0; i < nbits; i++) begin
      MOSI = frame[9 - i];
      if (ss_at_last && i == 9) SS_n = 1'b1;
      tick();
    end
    MOSI = 1'b0;
  endtask

  task automatic releaseSS();
    SS_n = 1'b1;
    MOSI = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    // Reset state
    #12;
    checkOutput("reset_rx_valid", 32'(rx_valid), 0);
    checkOutput("reset_rx_data", 32'(rx_data), 0);
    checkOutput("reset_miso", 32'(MISO), 0);
    checkOutput("reset_frame_err", 32'(frame_err), 0);
    checkOutput("reset_state", 32'(dut.state_q), 32'(IDLE));
    tick();
    rst_n = 1'b1;
    tick();

    // Write frame, then trailing bits that must be ignored
    applyStimulus(1'b0, 10'h005, 10, 1'b0, WRITE);
    for (int i = 0; i < 3; i++) begin
      MOSI = 1'b1;
      tick();
    end
    releaseSS();
    checkOutput("rx_count_write", 32'(rx_seen), 32'(rx_pushed));

    // Read address, stray tx_valid while idle, then read data with A5 shift-out
    applyStimulus(1'b1, 10'h205, 10, 1'b0, READ_ADD);
    checkOutput("rd_addr_seen_set", 32'(dut.rd_addr_seen_q), 1);
    releaseSS();
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    applyStimulus(1'b1, 10'h3C3, 10, 1'b0, READ_DATA);
    checkOutput("rd_addr_seen_clr", 32'(dut.rd_addr_seen_q), 0);
    tick();
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    pushTx(8'hA5);
    tick();
    tx_valid = 1'b0;
    tx_data = 8'h00;
    repeat (8) tick();
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    checkOutput("miso_queue_drained", 32'(miso_exp_q.size()), 0);
    releaseSS();

    // Abort after 4 bits while a read address is pending
    applyStimulus(1'b1, 10'h2F0, 10, 1'b0, READ_ADD);
    releaseSS();
    applyStimulus(1'b1, 10'h3AA, 4, 1'b0, READ_DATA);
    SS_n = 1'b1;
`ifdef SPI_FRAME_ERR_EN
    err_exp = 1'b1;
`else
    err_exp = 1'b0;
`endif
    tick();
    checkOutput("abort_state", 32'(dut.state_q), 32'(IDLE));
    checkOutput("abort_frame_err", 32'(frame_err), 32'(err_exp));
    checkOutput("abort_rd_addr_seen", 32'(dut.rd_addr_seen_q), 1);
    tick();
    checkOutput("abort_frame_err_low", 32'(frame_err), 0);
    checkOutput("rx_count_abort", 32'(rx_seen), 32'(rx_pushed));

    // Deselect during shift-out stops MISO
    applyStimulus(1'b1, 10'h301, 10, 1'b0, READ_DATA);
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    pushTx(8'h3C);
    tick();
    tx_valid = 1'b0;
    tick();
    tick();
    SS_n = 1'b1;
    miso_exp_q.delete();
    tick();
    tick();

    // Deselect on the cycle of the last bit still delivers the frame once
    applyStimulus(1'b0, 10'h2A7, 10, 1'b1, WRITE);
    checkOutput("late_ss_state", 32'(dut.state_q), 32'(IDLE));
    checkOutput("late_ss_frame_err", 32'(frame_err), 0);
    tick();
    checkOutput("rx_count_late_ss", 32'(rx_seen), 32'(rx_pushed));

    // Asynchronous reset in the middle of a shift-out
    applyStimulus(1'b1, 10'h211, 10, 1'b0, READ_ADD);
    releaseSS();
    applyStimulus(1'b1, 10'h3FF, 10, 1'b0, READ_DATA);
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    pushTx(8'hFF);
    tick();
    tx_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_miso", 32'(MISO), 0);
    checkOutput("async_rst_state", 32'(dut.state_q), 32'(IDLE));
    checkOutput("async_rst_rx_data", 32'(rx_data), 0);
    checkOutput("async_rst_rd_addr_seen", 32'(dut.rd_addr_seen_q), 0);
    miso_exp_q.delete();
    SS_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    checkOutput("rx_count_final", 32'(rx_seen), 32'(rx_pushed));
    checkOutput("rx_queue_empty", 32'(rx_exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
